// File: rtl/line_window_reader_if.sv
// Signal bundle shared by the line-buffer bank, the window reader and the
// convolution engine; clock and reset stay outside the bundle.
interface line_window_reader_if #(
  parameter int DATA_RES       = 8,
  parameter int KERNEL_WIDTH   = 3,
  parameter int MAX_LINE_WIDTH = 32
);
  localparam int AW = $clog2(MAX_LINE_WIDTH);
  localparam int WW = KERNEL_WIDTH * KERNEL_WIDTH * DATA_RES;

  logic          start_i;
  logic [AW-1:0] image_dimension_i;
  logic          line_done_i;
  logic [WW-1:0] rows_i;
  logic [AW-1:0] read_address_o;
  logic [WW-1:0] window_o;
  logic          window_valid_o;
  logic          window_ready_i;
  logic [AW-1:0] col_o;
  logic [AW-1:0] row_o;
  logic          line_release_o;
  logic          frame_done_o;
  logic          busy_o;
  logic          overflow_o;

  modport master (
    output start_i, image_dimension_i, line_done_i, rows_i, window_ready_i,
    input  read_address_o, window_o, window_valid_o, col_o, row_o,
           line_release_o, frame_done_o, busy_o, overflow_o
  );

  modport slave (
    input  start_i, image_dimension_i, line_done_i, rows_i, window_ready_i,
    output read_address_o, window_o, window_valid_o, col_o, row_o,
           line_release_o, frame_done_o, busy_o, overflow_o
  );
endinterface

// File: rtl/line_window_reader.sv
// Read-side sequencer for the CNN line-buffer bank: waits for K resident lines,
// sweeps the column address and hands out KxK windows over valid/ready.
module line_window_reader #(
  parameter int DATA_RES       = 8,
  parameter int KERNEL_WIDTH   = 3,
  parameter int MAX_LINE_WIDTH = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  line_window_reader_if.slave bus
);
  localparam int AW = $clog2(MAX_LINE_WIDTH);
  localparam int WW = KERNEL_WIDTH * KERNEL_WIDTH * DATA_RES;
  localparam int CW = $clog2(KERNEL_WIDTH + 1);

  localparam logic [AW:0]   DIM_MIN = (AW+1)'(KERNEL_WIDTH);
  localparam logic [AW:0]   DIM_MAX = (AW+1)'(MAX_LINE_WIDTH);
  localparam logic [AW-1:0] K_AW    = AW'(KERNEL_WIDTH);
  localparam logic [CW-1:0] K_CNT   = CW'(KERNEL_WIDTH);

  typedef enum logic [2:0] {IDLE, WAIT_LINES, SWEEP, RELEASE, DONE} state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [AW-1:0] r_lastIdx;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_col;
  logic [AW-1:0] r_rowOut;
  logic [WW-1:0] r_window;
  logic          r_valid;
  logic          r_overflow;
  logic [CW-1:0] r_linesAvail;
  logic          w_startOk;
  logic          w_adv;
  logic          w_capture;
  logic          w_release;
  logic          w_done;
  logic          w_busy;

  // Widen by one bit so D == MAX_LINE_WIDTH stays comparable.
  assign w_startOk = bus.start_i
                  && ({1'b0, bus.image_dimension_i} >= DIM_MIN)
                  && ({1'b0, bus.image_dimension_i} <= DIM_MAX);
  assign w_adv     = !r_valid || bus.window_ready_i;
  assign w_capture = (r_state == SWEEP) && w_adv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_release   = 1'b0;
    w_done      = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_startOk) w_stateNext = WAIT_LINES;
      end
      WAIT_LINES: if (r_linesAvail >= K_CNT) w_stateNext = SWEEP;
      SWEEP:      if (w_adv && (r_addr == r_lastIdx)) w_stateNext = RELEASE;
      RELEASE: begin
        w_release   = 1'b1;
        w_stateNext = (r_row == r_lastIdx) ? DONE : WAIT_LINES;
      end
      DONE: begin
        w_done      = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // r_lastIdx holds D-K, the last legal top-left index in both directions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lastIdx <= '0;
      r_row     <= '0;
      r_addr    <= '0;
    end else if ((r_state == IDLE) && w_startOk) begin
      r_lastIdx <= bus.image_dimension_i - K_AW;
      r_row     <= '0;
      r_addr    <= '0;
    end else if (w_capture && (r_addr != r_lastIdx)) begin
      r_addr <= r_addr + AW'(1);
    end else if (w_release) begin
      r_addr <= '0;
      if (r_row != r_lastIdx) r_row <= r_row + AW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_window <= '0;
      r_valid  <= 1'b0;
      r_col    <= '0;
      r_rowOut <= '0;
    end else if (w_capture) begin
      r_window <= bus.rows_i;
      r_valid  <= 1'b1;
      r_col    <= r_addr;
      r_rowOut <= r_row;
    end else if (bus.window_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  // End of frame discards the K-1 lines still resident.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_linesAvail <= '0;
      r_overflow   <= 1'b0;
    end else if (w_done) begin
      r_linesAvail <= '0;
    end else if (bus.line_done_i && !w_release) begin
      if (r_linesAvail == K_CNT) r_overflow   <= 1'b1;
      else                       r_linesAvail <= r_linesAvail + CW'(1);
    end else if (!bus.line_done_i && w_release) begin
      r_linesAvail <= r_linesAvail - CW'(1);
    end
  end

  assign bus.read_address_o = r_addr;
  assign bus.window_o       = r_window;
  assign bus.window_valid_o = r_valid;
  assign bus.col_o          = r_col;
  assign bus.row_o          = r_rowOut;
  assign bus.line_release_o = w_release;
  assign bus.frame_done_o   = w_done;
  assign bus.busy_o         = w_busy;
  assign bus.overflow_o     = r_overflow;
endmodule

// File: doc/line_window_reader.md
# line_window_reader

Read-side sequencer for the CNN line-buffer bank. It counts completed lines reported by the writer and, once KERNEL_WIDTH lines are resident, sweeps the column read address across the buffers. Each KERNEL_WIDTH x KERNEL_WIDTH window is captured into a registered output that the convolution engine consumes through a valid/ready handshake. After each swept row it releases the oldest line back to the writer, and it signals end of frame.

## Interface
- DATA_RES, 8, bits per pixel
- KERNEL_WIDTH, 3, window side K (rows and columns)
- MAX_LINE_WIDTH, 32, maximum image side; AW = $clog2(MAX_LINE_WIDTH)

- clk_i  input  1  single clock, all state on rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  begin a frame; sampled only in IDLE
- image_dimension_i  input  AW  square image side D; latched on accepted start_i
- line_done_i  input  1  one-cycle pulse per complete line written by the writer
- rows_i  input  K*K*DATA_RES  combinational read data of the K line buffers at read_address_o; oldest row in MSBs, leftmost pixel MSB within each row
- read_address_o  output  AW  registered column address driven to all K buffers
- window_o  output  K*K*DATA_RES  captured window, same packing as rows_i
- window_valid_o  output  1  window_o holds an unconsumed window
- window_ready_i  input  1  consumer accepts window_o this cycle
- col_o, row_o  output  AW  top-left coordinate of window_o
- line_release_o  output  1  one-cycle pulse: oldest line may be overwritten
- frame_done_o  output  1  one-cycle pulse after the last window is captured
- busy_o  output  1  high in every state except IDLE
- overflow_o  output  1  sticky: line_done_i arrived with K lines already resident

## Operation
- Reset: all outputs 0, lines_avail=0, state IDLE.
- Accepted start: start_i in IDLE with K <= D <= MAX_LINE_WIDTH. It latches D, clears row and col, and goes to WAIT_LINES. An out-of-range start_i is ignored. start_i outside IDLE is ignored.
- lines_avail counter (0..K): +1 on line_done_i, -1 on line_release_o. If both occur in the same cycle, the net change is 0. If line_done_i arrives with lines_avail==K and no release that cycle, the counter holds and overflow_o is set (cleared only by reset).
- Advance condition: adv = !window_valid_o || window_ready_i.
- State machine:
  - IDLE -> WAIT_LINES on accepted start.
  - WAIT_LINES -> SWEEP when lines_avail >= K. read_address_o is 0 on entry.
  - SWEEP, on each adv:
    - window_o <= rows_i; window_valid_o <= 1; col_o <= read_address_o; row_o <= row.
    - If read_address_o == D-K, go to RELEASE; otherwise read_address_o += 1.
  - SWEEP while stalled (!adv): read_address_o and window_o are held.
  - SWEEP with no capture: if window_ready_i is high and no capture occurs, window_valid_o drops to 0.
  - RELEASE (one cycle): pulse line_release_o and reset read_address_o to 0.
    - If row == D-K, go to DONE.
    - Otherwise row += 1 and go to WAIT_LINES.
  - DONE (one cycle): pulse frame_done_o, set lines_avail to 0 (remaining K-1 lines discarded), go to IDLE.
- Consumer handshake outside SWEEP: window_valid_o persists across RELEASE, DONE and IDLE until window_ready_i accepts it. window_o, col_o and row_o stay stable while window_valid_o=1 && !window_ready_i.
- Window count: (D-K+1) per row, (D-K+1)^2 per frame.
- Address width: arithmetic is AW bits; D-K is computed at start and never underflows because the range is checked at start.

## Timing
- Read path: read_address_o is registered. rows_i is combinational from it, and the capture happens on the same rising edge.
- First window: window_valid_o rises 1 cycle after WAIT_LINES->SWEEP.
- Throughput: 1 window/cycle while window_ready_i is held high.
- Row-end overhead: RELEASE adds 1 bubble cycle per row. WAIT_LINES adds at least 1 cycle.
- line_release_o: asserted the cycle after the last window of a row is captured.
- frame_done_o: asserted 2 cycles after the last capture of the frame.
- Reset mid-frame: immediate return to IDLE with all outputs 0. Any in-flight window is dropped.

## Test plan
- Basic frame, D=5, K=3, buffers modelled with pixel = row*16+col, 3 line_done_i pulses, ready always 1 -> 3 windows. First window_o rows are {00,01,02}, {10,11,12}, {20,21,22}. col_o 0,1,2; line_release_o one cycle after col 2.
- Full frame, D=5, K=3, writer supplies a new line after each release -> 9 windows with (row_o,col_o) (0,0)..(2,2), 3 line_release_o pulses, then frame_done_o. busy_o is low afterward.
- Backpressure: ready low for 4 cycles on the second window -> window_o, col_o=1 and read_address_o held for 4 cycles. No window is lost or duplicated.
- Simultaneous line_done_i with line_release_o at lines_avail=3 -> lines_avail stays 3 and overflow_o stays 0. A line_done_i at 3 without release -> overflow_o=1.
- Illegal start: start_i with D=2, K=3 -> remains IDLE, busy_o=0. start_i while busy -> ignored, latched D unchanged.
- Reset asserted mid-SWEEP -> all outputs 0 asynchronously. A new start_i works normally after deassertion.
